// File: rtl/alu_exec_seq_if.sv
// Handshake and operand/result bundle for the alu_exec_seq execution stage.
// The master modport is the producer/consumer side and the slave modport is the stage.
interface alu_exec_seq_if #(
    parameter int WIDTH = 16
);
    logic             In_Valid;
    logic             Out_InReady;
    logic [3:0]       In_Inst;
    logic [1:0]       In_Si;
    logic             PerformAddition;
    logic [WIDTH-1:0] In_A;
    logic [WIDTH-1:0] In_B;
    logic             Out_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] Out_Result;
    logic [3:0]       Out_ALUCtrl;
    logic             Out_Zero;
    logic             Out_Overflow;
    logic             Out_Busy;

    modport master (
        output In_Valid, In_Inst, In_Si, PerformAddition, In_A, In_B, In_Ready,
        input  Out_InReady, Out_Valid, Out_Result, Out_ALUCtrl, Out_Zero,
               Out_Overflow, Out_Busy
    );

    modport slave (
        input  In_Valid, In_Inst, In_Si, PerformAddition, In_A, In_B, In_Ready,
        output Out_InReady, Out_Valid, Out_Result, Out_ALUCtrl, Out_Zero,
               Out_Overflow, Out_Busy
    );
endinterface

// File: rtl/alu_exec_seq.sv
// Handshaked ALU execution stage: opcode/shift decode, registered result, bit-serial shifter.
// Define ALU_BARREL_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
//
// state | meaning
// IDLE  | no operation held, ready to accept
// SHIFT | serial shift in progress, one bit per cycle
// DONE  | result valid and held until the consumer takes it
module alu_exec_seq #(
    parameter int WIDTH = 16
) (
    input  logic         CLK,
    input  logic         Reset_N,
    alu_exec_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] C_ADD = 4'b0000;
    localparam logic [3:0] C_SUB = 4'b0001;
    localparam logic [3:0] C_AND = 4'b0010;
    localparam logic [3:0] C_OR  = 4'b0011;
    localparam logic [3:0] C_SLL = 4'b0101;
    localparam logic [3:0] C_SRL = 4'b0110;
    localparam logic [3:0] C_SLA = 4'b1100;
    localparam logic [3:0] C_SRA = 4'b1101;
    localparam logic [3:0] C_LUI = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] decode(input logic [3:0] inst, input logic [1:0] si,
                                          input logic padd);
        logic [3:0] c;
        c = C_ADD;
        if (!padd) begin
            case (inst)
                4'b0001, 4'b1001: c = C_SUB;
                4'b0010:          c = C_AND;
                4'b0011, 4'b1111: c = C_OR;
                4'b1110:          c = C_LUI;
                4'b0101: begin
                    case (si)
                        2'd0:    c = C_SLL;
                        2'd1:    c = C_SRL;
                        2'd2:    c = C_SLA;
                        default: c = C_SRA;
                    endcase
                end
                default:          c = C_ADD;
            endcase
        end
        return c;
    endfunction

    function automatic logic is_shift(input logic [3:0] c);
        return (c == C_SLL) || (c == C_SRL) || (c == C_SLA) || (c == C_SRA);
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             rdy_en_q;

    logic             in_ready;
    logic             accept;
    logic [3:0]       dec_ctrl;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf;

    assign dec_ctrl = decode(bus.In_Inst, bus.In_Si, bus.PerformAddition);
    assign amt      = bus.In_B[SHW-1:0];
    assign sum      = bus.In_A + bus.In_B;
    assign diff     = bus.In_A - bus.In_B;

    // rdy_en_q keeps Out_InReady low while reset is asserted without a reset-to-output comb path
    assign in_ready = rdy_en_q && ((state_q == S_IDLE) ||
                                   ((state_q == S_DONE) && bus.In_Ready));
    assign accept   = bus.In_Valid && in_ready;

    always_comb begin
        op_res = sum;
        op_ovf = (bus.In_A[MSB] == bus.In_B[MSB]) && (sum[MSB] != bus.In_A[MSB]);
        case (dec_ctrl)
            C_SUB: begin
                op_res = diff;
                op_ovf = (bus.In_A[MSB] == ~bus.In_B[MSB]) && (diff[MSB] != bus.In_A[MSB]);
            end
            C_AND: begin
                op_res = bus.In_A & bus.In_B;
                op_ovf = 1'b0;
            end
            C_OR: begin
                op_res = bus.In_A | bus.In_B;
                op_ovf = 1'b0;
            end
            C_LUI: begin
                op_res = bus.In_B << (WIDTH / 2);
                op_ovf = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] barrel_res;

    always_comb begin
        case (dec_ctrl)
            C_SRL:   barrel_res = bus.In_A >> amt;
            C_SRA:   barrel_res = $unsigned($signed(bus.In_A) >>> amt);
            default: barrel_res = bus.In_A << amt;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if ((state_q == S_DONE) && bus.In_Ready && !bus.In_Valid) begin
            state_d = S_IDLE;
        end
        if (accept) begin
            ctrl_d  = dec_ctrl;
            state_d = S_DONE;
            if (is_shift(dec_ctrl)) begin
                result_d = barrel_res;
                zero_d   = (barrel_res == '0);
                ovf_d    = 1'b0;
            end else begin
                result_d = op_res;
                zero_d   = (op_res == '0);
                ovf_d    = op_ovf;
            end
        end
        valid_d = (state_d == S_DONE);
        busy_d  = 1'b0;
    end
`else
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_step;

    always_comb begin
        case (ctrl_q)
            C_SRL:   sh_step = {1'b0, sh_q[MSB:1]};
            C_SRA:   sh_step = {sh_q[MSB], sh_q[MSB:1]};
            default: sh_step = {sh_q[MSB-1:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_SHIFT: begin
                sh_d  = sh_step;
                cnt_d = cnt_q - 1'b1;
                // The last shift lands directly in the result register
                if (cnt_q == SHW'(1)) begin
                    result_d = sh_step;
                    zero_d   = (sh_step == '0);
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.In_Ready && !bus.In_Valid) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            ctrl_d = dec_ctrl;
            if (is_shift(dec_ctrl)) begin
                if (amt == '0) begin
                    result_d = bus.In_A;
                    zero_d   = (bus.In_A == '0);
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    sh_d    = bus.In_A;
                    cnt_d   = amt;
                    state_d = S_SHIFT;
                end
            end else begin
                result_d = op_res;
                zero_d   = (op_res == '0);
                ovf_d    = op_ovf;
                state_d  = S_DONE;
            end
        end
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_SHIFT);
    end

    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign bus.Out_InReady  = in_ready;
    assign bus.Out_Valid    = valid_q;
    assign bus.Out_Result   = result_q;
    assign bus.Out_ALUCtrl  = ctrl_q;
    assign bus.Out_Zero     = zero_q;
    assign bus.Out_Overflow = ovf_q;
    assign bus.Out_Busy     = busy_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed, table-driven bench for alu_exec_seq (WIDTH=16): decode sweep, result vectors,
// reset mid-shift, backpressure and back-to-back streaming.
module tb_alu_exec_seq;
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic CLK;
    logic Reset_N;
    int   n_cmp;
    int   n_err;

    alu_exec_seq_if #(.WIDTH(16)) bus ();

    alu_exec_seq #(.WIDTH(16)) dut (
        .CLK     (CLK),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  inst;
        logic [1:0]  si;
        logic        padd;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ctrl;
        logic [15:0] res;
        logic        zero;
        logic        ovf;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends at posedge+1; the op is accepted on the edge just before return.
    task automatic send(input logic [3:0] inst, input logic [1:0] si, input logic padd,
                        input logic [15:0] a, input logic [15:0] b);
        int n;
        bus.In_Inst         = inst;
        bus.In_Si           = si;
        bus.PerformAddition = padd;
        bus.In_A            = a;
        bus.In_B            = b;
        bus.In_Valid        = 1'b1;
        #1;
        n = 0;
        while (!bus.Out_InReady && n < 64) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!bus.Out_InReady) check("accept_timeout", 32'(bus.Out_InReady), 32'd1);
        @(posedge CLK); #1;
        bus.In_Valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (!bus.Out_Valid && lat < 64) begin
            if (bus.Out_Busy) busy++;
            @(posedge CLK); #1;
            lat++;
        end
        if (!bus.Out_Valid) check("valid_timeout", 32'(bus.Out_Valid), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_op [16];
        logic [3:0] exp_sh [4];
        logic [3:0] e;
        int lat, busy, exp_lat, exp_busy;
        logic [15:0] held;

        n_cmp = 0;
        n_err = 0;
        Reset_N             = 1'b0;
        bus.In_Valid        = 1'b0;
        bus.In_Inst         = '0;
        bus.In_Si           = '0;
        bus.PerformAddition = 1'b0;
        bus.In_A            = '0;
        bus.In_B            = '0;
        bus.In_Ready        = 1'b1;

        exp_op = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h5, 4'h0, 4'h0,
                   4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE, 4'h3};
        exp_sh = '{4'h5, 4'h6, 4'hC, 4'hD};

        //           inst     si    padd  A         B         ctrl   result    z     o     lat name
        vecs[0]  = '{4'b0000, 2'd0, 1'b0, 16'h0003, 16'h0004, 4'h0, 16'h0007, 1'b0, 1'b0, 1, "add"};
        vecs[1]  = '{4'b0001, 2'd0, 1'b0, 16'h8000, 16'h0001, 4'h1, 16'h7FFF, 1'b0, 1'b1, 1, "sub_ovf"};
        vecs[2]  = '{4'b1001, 2'd0, 1'b0, 16'h0005, 16'h0005, 4'h1, 16'h0000, 1'b1, 1'b0, 1, "sub_zero"};
        vecs[3]  = '{4'b0010, 2'd0, 1'b0, 16'hF0F0, 16'h0FF0, 4'h2, 16'h00F0, 1'b0, 1'b0, 1, "and"};
        vecs[4]  = '{4'b1111, 2'd0, 1'b0, 16'hF000, 16'h000F, 4'h3, 16'hF00F, 1'b0, 1'b0, 1, "or"};
        vecs[5]  = '{4'b1110, 2'd0, 1'b0, 16'hABCD, 16'h0012, 4'hE, 16'h1200, 1'b0, 1'b0, 1, "lui"};
        vecs[6]  = '{4'b0100, 2'd0, 1'b0, 16'h7FFF, 16'h0001, 4'h0, 16'h8000, 1'b0, 1'b1, 1, "add_ovf"};
        vecs[7]  = '{4'b0101, 2'd3, 1'b0, 16'h8000, 16'h0004, 4'hD, 16'hF800, 1'b0, 1'b0, 5, "sra4"};
        vecs[8]  = '{4'b0101, 2'd1, 1'b0, 16'h8000, 16'h000F, 4'h6, 16'h0001, 1'b0, 1'b0, 16, "srl15"};
        vecs[9]  = '{4'b0101, 2'd0, 1'b0, 16'h0001, 16'h0003, 4'h5, 16'h0008, 1'b0, 1'b0, 4, "sll3"};
        vecs[10] = '{4'b0101, 2'd2, 1'b0, 16'hC001, 16'h0001, 4'hC, 16'h8002, 1'b0, 1'b0, 2, "sla1"};
        vecs[11] = '{4'b0101, 2'd1, 1'b0, 16'h1234, 16'h0010, 4'h6, 16'h1234, 1'b0, 1'b0, 1, "shift_amt0"};
        vecs[12] = '{4'b0010, 2'd0, 1'b1, 16'h0001, 16'hFFFF, 4'h0, 16'h0000, 1'b1, 1'b0, 1, "padd_force"};
        vecs[13] = '{4'b0001, 2'd0, 1'b0, 16'h7FFF, 16'hFFFF, 4'h1, 16'h8000, 1'b0, 1'b1, 1, "sub_ovf_neg"};
        vecs[14] = '{4'b0101, 2'd3, 1'b0, 16'h4000, 16'h0002, 4'hD, 16'h1000, 1'b0, 1'b0, 3, "sra_pos"};

        // Reset state
        #3;
        check("rst_valid",  32'(bus.Out_Valid),    32'd0);
        check("rst_result", 32'(bus.Out_Result),   32'd0);
        check("rst_ctrl",   32'(bus.Out_ALUCtrl),  32'd0);
        check("rst_zero",   32'(bus.Out_Zero),     32'd0);
        check("rst_ovf",    32'(bus.Out_Overflow), 32'd0);
        check("rst_busy",   32'(bus.Out_Busy),     32'd0);
        check("rst_inready", 32'(bus.Out_InReady), 32'd0);
        #9 Reset_N = 1'b1;
        #1 check("inready_before_edge", 32'(bus.Out_InReady), 32'd0);
        @(posedge CLK); #1;
        check("inready_after_release", 32'(bus.Out_InReady), 32'd1);

        // Result vectors
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].inst, vecs[i].si, vecs[i].padd, vecs[i].a, vecs[i].b);
            wait_valid(lat, busy);
            exp_lat  = BARREL ? 1 : vecs[i].lat;
            exp_busy = BARREL ? 0 : vecs[i].lat - 1;
            check({vecs[i].name, "_result"}, 32'(bus.Out_Result),   32'(vecs[i].res));
            check({vecs[i].name, "_ctrl"},   32'(bus.Out_ALUCtrl),  32'(vecs[i].ctrl));
            check({vecs[i].name, "_zero"},   32'(bus.Out_Zero),     32'(vecs[i].zero));
            check({vecs[i].name, "_ovf"},    32'(bus.Out_Overflow), 32'(vecs[i].ovf));
            check({vecs[i].name, "_lat"},    32'(lat),              32'(exp_lat));
            check({vecs[i].name, "_busy"},   32'(busy),             32'(exp_busy));
        end

        // Decode sweep with shift amount 0 so every op completes in one cycle
        for (int p = 0; p < 2; p++) begin
            for (int op = 0; op < 16; op++) begin
                for (int s = 0; s < 4; s++) begin
                    send(4'(op), 2'(s), 1'(p), 16'h0003, 16'h0000);
                    wait_valid(lat, busy);
                    e = (p == 1) ? 4'h0 : ((op == 5) ? exp_sh[s] : exp_op[op]);
                    check($sformatf("decode_op%0d_si%0d_pa%0d", op, s, p),
                          32'(bus.Out_ALUCtrl), 32'(e));
                    if (p == 1) check($sformatf("padd_add_op%0d_si%0d", op, s),
                                      32'(bus.Out_Result), 32'h0003);
                end
            end
        end

        // Reset mid-shift
        @(posedge CLK); #1;
        send(4'b0101, 2'd1, 1'b0, 16'h8000, 16'h000F);
        repeat (4) begin @(posedge CLK); #1; end
        check("midshift_busy", 32'(bus.Out_Busy), BARREL ? 32'd0 : 32'd1);
        #2 Reset_N = 1'b0;
        #1;
        check("midrst_valid",   32'(bus.Out_Valid),    32'd0);
        check("midrst_result",  32'(bus.Out_Result),   32'd0);
        check("midrst_ctrl",    32'(bus.Out_ALUCtrl),  32'd0);
        check("midrst_zero",    32'(bus.Out_Zero),     32'd0);
        check("midrst_ovf",     32'(bus.Out_Overflow), 32'd0);
        check("midrst_busy",    32'(bus.Out_Busy),     32'd0);
        check("midrst_inready", 32'(bus.Out_InReady),  32'd0);
        @(posedge CLK); #2 Reset_N = 1'b1;
        @(posedge CLK); #1;
        send(4'b0000, 2'd0, 1'b0, 16'd3, 16'd4);
        check("postrst_add_valid",  32'(bus.Out_Valid),  32'd1);
        check("postrst_add_result", 32'(bus.Out_Result), 32'h0007);

        // Backpressure
        @(posedge CLK); #1;
        bus.In_Ready = 1'b0;
        send(4'b0000, 2'd0, 1'b0, 16'd10, 16'd20);
        wait_valid(lat, busy);
        check("bp_result", 32'(bus.Out_Result), 32'd30);
        held = bus.Out_Result;
        bus.In_Inst  = 4'b0011;
        bus.In_Si    = 2'd0;
        bus.In_A     = 16'h0001;
        bus.In_B     = 16'h0002;
        bus.In_Valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_inready_low", 32'(bus.Out_InReady), 32'd0);
            @(posedge CLK); #1;
            check("bp_valid_held",  32'(bus.Out_Valid),   32'd1);
            check("bp_result_held", 32'(bus.Out_Result),  32'(held));
            check("bp_ctrl_held",   32'(bus.Out_ALUCtrl), 32'h0);
        end
        bus.In_Ready = 1'b1;
        #1;
        check("bp_inready_rise", 32'(bus.Out_InReady), 32'd1);
        @(posedge CLK); #1;
        bus.In_Valid = 1'b0;
        check("bp_new_result", 32'(bus.Out_Result),  32'h0003);
        check("bp_new_ctrl",   32'(bus.Out_ALUCtrl), 32'h3);
        check("bp_new_valid",  32'(bus.Out_Valid),   32'd1);

        // Back-to-back streaming
        @(posedge CLK); #1;
        bus.In_Valid = 1'b1;
        bus.In_Inst = 4'b0000; bus.In_A = 16'h0001; bus.In_B = 16'h0002;
        #1 check("b2b_rdy0", 32'(bus.Out_InReady), 32'd1);
        @(posedge CLK); #1;
        check("b2b_add", 32'(bus.Out_Result), 32'h0003);
        bus.In_Inst = 4'b0010; bus.In_A = 16'hF0F0; bus.In_B = 16'h0FF0;
        #1 check("b2b_rdy1", 32'(bus.Out_InReady), 32'd1);
        @(posedge CLK); #1;
        check("b2b_and", 32'(bus.Out_Result), 32'h00F0);
        bus.In_Inst = 4'b1110; bus.In_A = 16'h0000; bus.In_B = 16'h0012;
        #1 check("b2b_rdy2", 32'(bus.Out_InReady), 32'd1);
        @(posedge CLK); #1;
        bus.In_Valid = 1'b0;
        check("b2b_lui",       32'(bus.Out_Result),  32'h1200);
        check("b2b_lui_ctrl",  32'(bus.Out_ALUCtrl), 32'hE);
        check("b2b_lui_valid", 32'(bus.Out_Valid),   32'd1);
        @(posedge CLK); #1;
        check("b2b_drain_valid", 32'(bus.Out_Valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Parametrised, handshaked ALU execution stage that decodes the 4-bit instruction opcode and 2-bit shift selector into an ALU control code and computes the result. Sits between register read and writeback in the datapath. Generalises the combinational ALU-control decode to configurable datapath width and adds a registered, multi-cycle result path with valid/ready flow control and a bit-serial shifter.

## Interface
- WIDTH, 16, datapath width in bits; even, at least 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
- CLK  in  1  clock; all state updates on rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- In_Valid  in  1  operation offered.
- Out_InReady  out  1  stage can accept an operation this cycle.
- In_Inst  in  4  opcode.
- In_Si  in  2  shift type: 0 SLL, 1 SRL, 2 SLA, 3 SRA.
- PerformAddition  in  1  force ADD regardless of opcode.
- In_A  in  WIDTH  operand A.
- In_B  in  WIDTH  operand B; shift amount is In_B[SHW-1:0].
- Out_Valid  out  1  result available.
- In_Ready  in  1  consumer accepts result.
- Out_Result  out  WIDTH  result.
- Out_ALUCtrl  out  4  registered control code of the held operation.
- Out_Zero  out  1  Out_Result == 0.
- Out_Overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- Out_Busy  out  1  shift iteration in progress.

## Operation
- Decode, when accepted: PerformAddition=1 gives 0000 (ADD). Otherwise: 0000/0100/0111/1000/1100/1101 → 0000 ADD; 0001/1001 → 0001 SUB; 0010 → 0010 AND; 0011/1111 → 0011 OR; 1110 → 1110 LUI; 0101 → Si 0:0101, 1:0110, 2:1100, 3:1101; any other opcode → 0000.
- Arithmetic: ADD/SUB modulo 2^WIDTH. Overflow = operand signs equal (for SUB: A and ~B signs) and result sign differs. LUI = In_B << (WIDTH/2), low half zero. SLA is identical to SLL.
- States: IDLE, SHIFT, DONE.
- IDLE: Out_InReady=1. On In_Valid, latch operands and control code.
  - Non-shift op: result computed and registered; go to DONE.
  - Shift op with amount 0: Out_Result=A; go to DONE.
  - Shift op with amount n>0: load A into the shift register, counter=n; go to SHIFT.
- SHIFT: each cycle shift one bit (SRL fills 0; SRA replicates MSB; SLL/SLA fill 0) and decrement the counter. Go to DONE after the cycle in which the counter reaches 0. Out_Busy=1 and Out_InReady=0 throughout.
- DONE: Out_Valid=1; Out_Result, Out_ALUCtrl, Out_Zero and Out_Overflow are held stable until In_Ready.
  - On In_Ready: if In_Valid is also high, accept the new operation in the same cycle (back-to-back); otherwise go to IDLE.
  - Out_InReady = In_Ready in DONE.
- In_Valid when Out_InReady=0 is ignored; the producer must hold it.

## Timing
- Reset (asynchronous, any state, including mid-shift): state IDLE, counter 0. Out_Valid, Out_Result, Out_ALUCtrl, Out_Zero, Out_Overflow and Out_Busy all 0. Out_InReady=0 while Reset_N is low, and 1 from the first edge after release.
- Latency from accept edge to Out_Valid high:
  - non-shift ops and shift amount 0: 1 cycle;
  - shift amount n: n+1 cycles.
- Throughput: one non-shift op per cycle while In_Ready is held high.
- Outputs come from registers, except Out_InReady, which is combinational from state and In_Ready.

## Configuration
- ALU_BARREL_SHIFT_EN defined: shifts complete in a single cycle through a barrel shifter. The SHIFT state is never entered and Out_Busy stays 0. All shifts have 1-cycle latency.
- Not defined: bit-serial shifter exactly as described above.

## Test plan
- Reset mid-shift: SRL A=0x8000, B=15, assert Reset_N low at cycle 5 → all outputs 0 immediately; after release, ADD 3+4 gives Out_Result=0x0007 one cycle after accept.
- Decode sweep: every In_Inst × In_Si with PerformAddition both 0 and 1 → Out_ALUCtrl matches the mapping; PerformAddition=1 always gives 0000.
- SRA A=0x8000, B=4 → Out_Result=0xF800, Out_Valid 5 cycles after accept (1 without macro-enabled serial path, i.e. with ALU_BARREL_SHIFT_EN); Out_Busy high 4 cycles.
- SUB A=0x8000, B=0x0001 → 0x7FFF, Out_Overflow=1; SUB 5−5 → 0, Out_Zero=1.
- Backpressure: In_Ready low for 3 cycles in DONE → result stable; a new In_Valid op is not accepted until In_Ready rises, then accepted the same cycle.
- Back-to-back: ADD, AND 0xF0F0&0x0FF0, LUI B=0x12 streamed with In_Ready=1 → results 1 cycle apart; LUI result = 0x1200.
